register_bank: RTL

Two-read/two-write general-purpose register file for the 16-bit multicycle processor, sitting directly downstream of the control unit. It consumes RegR1/RegR2/RegW1/RegW2 and backup/restore. It latches operands for the ALU and accepts write-backs from the Regsrc mux. A bounded shadow stack saves and restores the callee-saved register range on cal/ret.

---
 rtl/register_bank_pkg.sv | 21 ++
 rtl/backup_stack.sv | 59 +++++
 rtl/register_bank.sv | 100 ++++++++++
 3 files changed

// File: rtl/register_bank_pkg.sv
// Shared sizing constants and helpers for the 16-bit processor register bank
// and its shadow backup stack.
package register_bank_pkg;

    localparam int WIDTH   = 16;
    localparam int NREGS   = 16;
    localparam int SAVE_LO = 8;
    localparam int DEPTH   = 4;

    localparam int AW    = $clog2(NREGS);
    localparam int SPW   = $clog2(DEPTH + 1);
    localparam int FW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NSAVE = NREGS - SAVE_LO;

    localparam logic [AW-1:0] R0 = '0;

    function automatic logic in_saved(input logic [AW-1:0] a);
        return a >= AW'(SAVE_LO);
    endfunction

endpackage

// File: rtl/backup_stack.sv
// Bounded shadow stack holding snapshots of the callee-saved register range,
// with push/pop arbitration and sticky error reporting.
module backup_stack
    import register_bank_pkg::*;
(
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         backup,
    input  logic                         restore,
    input  logic [NSAVE-1:0][WIDTH-1:0]  save_data,
    output logic [NSAVE-1:0][WIDTH-1:0]  restore_data,
    output logic                         pop,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         conflict
);

    logic [NSAVE-1:0][WIDTH-1:0] frames [DEPTH];
    logic [SPW-1:0]              sp;
    logic                        push;

    assign stack_full   = (sp == SPW'(DEPTH));
    assign stack_empty  = (sp == '0);
    assign push         = backup & ~restore & ~stack_full;
    assign pop          = restore & ~backup & ~stack_empty;
    assign restore_data = frames[FW'(sp - 1'b1)];

    // A simultaneous backup/restore is rejected outright and only raises conflict.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int d = 0; d < DEPTH; d++) begin
                frames[d] <= '0;
            end
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            if (push) begin
                frames[FW'(sp)] <= save_data;
                sp              <= sp + 1'b1;
            end else if (pop) begin
                sp <= sp - 1'b1;
            end
            if (backup && restore) begin
                conflict <= 1'b1;
            end
            if (backup && !restore && stack_full) begin
                overflow <= 1'b1;
            end
            if (restore && !backup && stack_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_bank.sv
// Two-read/two-write register file with write-through bypass on the read
// latches and a shadow stack for the callee-saved range.
module register_bank
    import register_bank_pkg::*;
(
    input  logic             clk,
    input  logic             Reset,
    input  logic             RegR1,
    input  logic             RegR2,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    input  logic             RegW1,
    input  logic             RegW2,
    input  logic [AW-1:0]    waddr1,
    input  logic [AW-1:0]    waddr2,
    input  logic [WIDTH-1:0] wdata1,
    input  logic [WIDTH-1:0] wdata2,
    input  logic             backup,
    input  logic             restore,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             overflow,
    output logic             underflow,
    output logic             conflict
);

    logic [WIDTH-1:0]            regs   [NREGS];
    logic [WIDTH-1:0]            wr_val [NREGS];
    logic [NSAVE-1:0][WIDTH-1:0] save_data;
    logic [NSAVE-1:0][WIDTH-1:0] restore_data;
    logic                        pop;
    logic                        we1;
    logic                        we2;

    always_comb begin
        save_data = '0;
        for (int j = 0; j < NSAVE; j++) begin
            save_data[j] = regs[SAVE_LO + j];
        end
    end

    backup_stack u_stack (
        .clk          (clk),
        .Reset        (Reset),
        .backup       (backup),
        .restore      (restore),
        .save_data    (save_data),
        .restore_data (restore_data),
        .pop          (pop),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .conflict     (conflict)
    );

    // Writes into the saved range lose to a restore and are not bypassed either.
    assign we1 = RegW1 && (waddr1 != R0) && !(pop && in_saved(waddr1));
    assign we2 = RegW2 && (waddr2 != R0) && !(pop && in_saved(waddr2));

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            wr_val[i] = regs[i];
            if (we1 && waddr1 == AW'(i)) begin
                wr_val[i] = wdata1;
            end
            if (we2 && waddr2 == AW'(i)) begin
                wr_val[i] = wdata2;
            end
        end
        wr_val[0] = '0;
    end

    // Read latches sample the post-write view, which gives the bypass for free.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            if (RegR1) begin
                rdata1 <= wr_val[raddr1];
            end
            if (RegR2) begin
                rdata2 <= wr_val[raddr2];
            end
            for (int i = 0; i < SAVE_LO; i++) begin
                regs[i] <= wr_val[i];
            end
            for (int j = 0; j < NSAVE; j++) begin
                regs[SAVE_LO + j] <= pop ? restore_data[j] : wr_val[SAVE_LO + j];
            end
        end
    end

endmodule
